// File: rtl/fwd_pkg.sv
// fwd_pkg: width helpers and bypass-select encoding shared by the forwarding scoreboard.
package fwd_pkg;
  localparam int SEL_RF = 0;
  localparam int SEL_LANE_BASE = 1;
  function automatic int lat_width(input int maxlat);
    return $clog2(maxlat + 1);
  endfunction
  function automatic int sel_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction
endpackage

// File: rtl/sb_entry.sv
// sb_entry: per-register countdown to bypass availability plus the producing lane.
module sb_entry #(
  parameter int LATW = 2,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            set,
  input  logic [LATW-1:0] set_lat,
  input  logic [SELW-1:0] set_lane,
  output logic [LATW-1:0] count,
  output logic [SELW-1:0] lane
);
  always_ff @(posedge clk)
    if (reset) begin
      count <= '0;
      lane  <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (set) begin
      count <= set_lat;
      lane  <= set_lane;
    end else if (count != '0) begin
      count <= count - LATW'(1);
    end
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: multi-lane issue scoreboard choosing register-file or bypass sources and stalling on hazards.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int NREG   = 32,
  parameter int MAXLAT = 3,
  parameter int REGW   = $clog2(NREG),
  parameter int LATW   = lat_width(MAXLAT),
  parameter int SELW   = sel_width(LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [LANES-1:0]      issue_valid,
  input  logic [LANES-1:0]      regwrite,
  input  logic [LANES*REGW-1:0] rd,
  input  logic [LANES*LATW-1:0] lat,
  input  logic [LANES*REGW-1:0] rs,
  input  logic [LANES*REGW-1:0] rt,
  output logic [LANES*SELW-1:0] fwda,
  output logic [LANES*SELW-1:0] fwdb,
  output logic                  stall,
  output logic [NREG-1:0]       busy
);
  logic [LATW-1:0]    count_a [NREG];
  logic [SELW-1:0]    lane_a  [NREG];
  logic [LATW-1:0]    eff_lat [LANES];
  logic [2*LANES-1:0] stall_vec;
  logic               fire;
  assign count_a[0] = '0;
  assign lane_a[0]  = '0;
  assign busy[0]    = 1'b0;
  assign stall = |stall_vec;
  assign fire  = |issue_valid && !stall && !flush;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LATW-1:0] l;
    logic [SELW-1:0] sel [2];
    assign l = lat[k*LATW +: LATW];
    // zero latency still needs one cycle before the bypass bus is valid
    assign eff_lat[k] = 32'(l) > MAXLAT ? LATW'(MAXLAT) : (l == '0 ? LATW'(1) : l);
    assign fwda[k*SELW +: SELW] = sel[0];
    assign fwdb[k*SELW +: SELW] = sel[1];
    for (genvar o = 0; o < 2; o++) begin : g_op
      logic [REGW-1:0] s;
      logic [LATW-1:0] c;
      logic            raw;
      assign s = (o == 0) ? rs[k*REGW +: REGW] : rt[k*REGW +: REGW];
      assign c = count_a[s];
      assign sel[o] = (s != '0 && c == LATW'(1)) ? lane_a[s] + SELW'(SEL_LANE_BASE) : SELW'(SEL_RF);
      always_comb begin
        raw = 1'b0;
        for (int j = 0; j < k; j++)
          raw |= issue_valid[j] && regwrite[j] && rd[j*REGW +: REGW] != '0 && rd[j*REGW +: REGW] == s;
      end
      assign stall_vec[2*k+o] = issue_valid[k] && (raw || (s != '0 && c > LATW'(1)));
    end
  end
  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic            hit;
    logic [LATW-1:0] nlat;
    logic [SELW-1:0] nlane;
    // later lanes overwrite earlier ones so the youngest writer wins
    always_comb begin
      hit   = 1'b0;
      nlat  = '0;
      nlane = '0;
      for (int k = 0; k < LANES; k++)
        if (issue_valid[k] && regwrite[k] && rd[k*REGW +: REGW] == REGW'(r)) begin
          hit   = 1'b1;
          nlat  = eff_lat[k];
          nlane = SELW'(k);
        end
    end
    sb_entry #(.LATW(LATW), .SELW(SELW)) u_entry (
      .clk(clk), .reset(reset), .flush(flush), .set(fire && hit),
      .set_lat(nlat), .set_lane(nlane), .count(count_a[r]), .lane(lane_a[r])
    );
    assign busy[r] = count_a[r] != '0;
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: vector table, directed hazard sequences and randomized model comparison.
module tb_fwd_scoreboard;
  logic        clk = 1'b0;
  logic        reset, flush, stall;
  logic [1:0]  issue_valid, regwrite;
  logic [9:0]  rd, rs, rt;
  logic [3:0]  lat, fwda, fwdb;
  logic [31:0] busy;
  int checks = 0, failures = 0;
  int mcnt [32];
  int mln  [32];

  fwd_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid), .regwrite(regwrite),
    .rd(rd), .lat(lat), .rs(rs), .rt(rt), .fwda(fwda), .fwdb(fwdb), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v, w;
    logic [4:0] d0, d1, s0, t0, s1, t1;
    logic       exp_stall;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, w, input logic [4:0] d0, d1, input logic [1:0] l0, l1,
                       input logic [4:0] s0, t0, s1, t1);
    issue_valid = v; regwrite = w; rd = {d1, d0}; lat = {l1, l0}; rs = {s1, s0}; rt = {t1, t0};
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int clamp_lat(input int l);
    return l == 0 ? 1 : (l > 3 ? 3 : l);
  endfunction

  function automatic int model_sel(input int s);
    return (s != 0 && mcnt[s] == 1) ? mln[s] + 1 : 0;
  endfunction

  function automatic int model_stall();
    int st = 0;
    for (int k = 0; k < 2; k++) begin
      int a = rs[k*5 +: 5], b = rt[k*5 +: 5];
      if (!issue_valid[k]) continue;
      if ((a != 0 && mcnt[a] > 1) || (b != 0 && mcnt[b] > 1)) st = 1;
      for (int j = 0; j < k; j++) begin
        int d = rd[j*5 +: 5];
        if (issue_valid[j] && regwrite[j] && d != 0 && (d == a || d == b)) st = 1;
      end
    end
    return st;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = mcnt[r] != 0;
    return b;
  endfunction

  task automatic model_edge(input int st);
    if (reset || flush) begin
      for (int r = 0; r < 32; r++) begin mcnt[r] = 0; if (reset) mln[r] = 0; end
    end else begin
      for (int r = 0; r < 32; r++) if (mcnt[r] > 0) mcnt[r]--;
      if (issue_valid != 0 && st == 0)
        for (int k = 0; k < 2; k++) begin
          int d = rd[k*5 +: 5];
          if (issue_valid[k] && regwrite[k] && d != 0) begin
            mcnt[d] = clamp_lat(lat[k*2 +: 2]);
            mln[d] = k;
          end
        end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();
    chk("reset_stall", stall, 0);
    chk("reset_fwda", fwda, 0);
    chk("reset_fwdb", fwdb, 0);
    chk("reset_busy", busy, 0);

    vecs[0] = '{2'b11, 2'b01, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b1};
    vecs[1] = '{2'b11, 2'b01, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1};
    vecs[2] = '{2'b01, 2'b01, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b0};
    vecs[3] = '{2'b11, 2'b00, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b0};
    vecs[4] = '{2'b11, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0};
    vecs[5] = '{2'b11, 2'b10, 5'd0, 5'd9, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      drive(vecs[i].v, vecs[i].w, vecs[i].d0, vecs[i].d1, 1, 1, vecs[i].s0, vecs[i].t0, vecs[i].s1, vecs[i].t1);
      #2;
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_fwda", i), fwda, 0);
    end

    // forward from a 1-cycle producer
    do_reset();
    drive(2'b01, 2'b01, 5, 0, 1, 0, 0, 0, 0, 0);
    #2 chk("s033_issue_stall", stall, 0);
    tick();
    drive(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
    #2 chk("s033_fwda1", fwda[3:2], 1);
    chk("s033_stall", stall, 0);

    // 3-cycle producer: two stall cycles, bypass, then register file
    do_reset();
    drive(2'b01, 2'b01, 8, 0, 3, 0, 0, 0, 0, 0);
    tick();
    drive(2'b01, 2'b00, 0, 0, 0, 0, 8, 0, 0, 0);
    #2 chk("s034_stall_c1", stall, 1);
    tick();
    #2 chk("s034_stall_c2", stall, 1);
    tick();
    #2 chk("s034_stall_c3", stall, 0);
    chk("s034_fwda_c3", fwda[1:0], 1);
    tick();
    #2 chk("s034_fwda_c4", fwda[1:0], 0);

    // intra-bundle RAW blocks the whole bundle until it is split
    do_reset();
    drive(2'b11, 2'b01, 9, 0, 2, 0, 0, 0, 9, 0);
    #2 chk("s035_stall", stall, 1);
    tick();
    chk("s035_no_set", busy[9], 0);
    drive(2'b01, 2'b01, 9, 0, 2, 0, 0, 0, 0, 0);
    #2 chk("s035_split_stall", stall, 0);
    tick();
    chk("s035_split_busy", busy[9], 1);

    // WAW within a bundle: lane 1 wins
    do_reset();
    drive(2'b11, 2'b11, 4, 4, 3, 1, 0, 0, 0, 0);
    tick();
    drive(2'b01, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
    #2 chk("s036_fwda0", fwda[1:0], 2);
    chk("s036_stall", stall, 0);

    // flush drops a pending write
    do_reset();
    drive(2'b01, 2'b01, 7, 0, 3, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    chk("s037_pre_busy", busy[7], 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(2'b01, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0);
    #2 chk("s037_busy", busy[7], 0);
    chk("s037_fwda", fwda[1:0], 0);
    chk("s037_stall", stall, 0);

    // register zero is never tracked
    do_reset();
    drive(2'b01, 2'b01, 0, 0, 3, 0, 0, 0, 0, 0);
    #2 chk("s038_stall", stall, 0);
    chk("s038_fwda", fwda, 0);
    tick();
    chk("s038_busy", busy, 0);

    // flush blocks a concurrent issue
    do_reset();
    drive(2'b01, 2'b01, 6, 0, 2, 0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_blocks_issue", busy[6], 0);

    // reset mid-countdown beats a concurrent issue
    do_reset();
    drive(2'b01, 2'b01, 3, 0, 3, 0, 0, 0, 0, 0);
    tick();
    drive(2'b01, 2'b01, 10, 0, 3, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_busy", busy, 0);

    // randomized run against the reference model
    do_reset();
    for (int r = 0; r < 32; r++) begin mcnt[r] = 0; mln[r] = 0; end
    for (int n = 0; n < 600; n++) begin
      int st;
      drive(2'($urandom), 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom), 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      flush = $urandom_range(0, 15) == 0;
      reset = $urandom_range(0, 63) == 0;
      #2;
      st = model_stall();
      chk("rnd_stall", stall, st);
      chk("rnd_fwda", fwda, {2'(model_sel(rs[9:5])), 2'(model_sel(rs[4:0]))});
      chk("rnd_fwdb", fwdb, {2'(model_sel(rt[9:5])), 2'(model_sel(rt[4:0]))});
      chk("rnd_busy", busy, model_busy());
      @(posedge clk);
      model_edge(st);
      #1;
    end
    reset = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
